// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA serial paths: receive FSM encoding and
// bit-timer sizing helpers common to both the transmitter and the receiver.
package acia_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Peripheral clock ticks per serial symbol.
    function automatic int sym_cnt(input int clk_freq, input int sym_rate);
        return clk_freq / sym_rate;
    endfunction

    // Width of a down-counter that spans one symbol.
    function automatic int sym_width(input int clk_freq, input int sym_rate);
        return $clog2(sym_cnt(clk_freq, sym_rate));
    endfunction

endpackage

// File: rtl/acia_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high lines do not look active.
module acia_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Free-running on clk; no enable so the latency is always two cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/acia_rx.sv
// ACIA receive path: decodes an 8N1 frame into a byte and holds it with
// full/framing/overrun status until the CPU side pulses rx_read.
module acia_rx
    import acia_pkg::*;
#(
    parameter int clk_freq = 4000000,
    parameter int sym_rate = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pclk,
    input  logic       rx_serial,
    input  logic       rx_read,
    output logic [7:0] rx_dat,
    output logic       rx_full,
    output logic       rx_err,
    output logic       rx_ovr
);

    localparam int SYM_CNT = sym_cnt(clk_freq, sym_rate);
    localparam int HALF    = SYM_CNT / 2;
    localparam int SCW     = sym_width(clk_freq, sym_rate);

    // Reload constants deliberately truncated to the timer width.
    localparam logic [SCW-1:0] SYM_M1  = SCW'(SYM_CNT - 1);
    localparam logic [SCW-1:0] HALF_M1 = SCW'(HALF - 1);

    logic            rxs;
    rx_state_t       state, state_nx;
    logic [SCW-1:0]  timer, timer_nx;
    logic [2:0]      bit_cnt, bit_cnt_nx;
    logic [7:0]      shreg, shreg_nx;
    logic            load;
    logic            tmr_zero;

    acia_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx_serial),
        .q       (rxs)
    );

    assign tmr_zero = (timer == '0);

    // FSM, bit timer, bit counter and shift register state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= 8'h00;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
        end
    end

    // Next-state decode; everything holds on cycles without a pclk tick.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        load       = 1'b0;
        if (pclk) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_nx = START;
                        timer_nx = HALF_M1;
                    end
                end
                START: begin
                    if (tmr_zero) begin
                        timer_nx = SYM_M1;
                        if (rxs) begin
                            // Start bit gone at mid-bit: treat as a glitch.
                            state_nx = IDLE;
                        end else begin
                            state_nx   = DATA;
                            bit_cnt_nx = '0;
                        end
                    end else begin
                        timer_nx = timer - SCW'(1);
                    end
                end
                DATA: begin
                    if (tmr_zero) begin
                        timer_nx   = SYM_M1;
                        shreg_nx   = {rxs, shreg[7:1]};
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state_nx = STOP;
                    end else begin
                        timer_nx = timer - SCW'(1);
                    end
                end
                STOP: begin
                    if (tmr_zero) begin
                        timer_nx = SYM_M1;
                        load     = 1'b1;
                        state_nx = rxs ? IDLE : BREAK;
                    end else begin
                        timer_nx = timer - SCW'(1);
                    end
                end
                BREAK: begin
                    // A held-low line yields one byte; rearm only once it idles.
                    if (rxs)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Received byte and status; a load on the same edge as rx_read wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_dat  <= 8'h00;
            rx_full <= 1'b0;
            rx_err  <= 1'b0;
            rx_ovr  <= 1'b0;
        end else begin
            if (rx_read) begin
                rx_full <= 1'b0;
                rx_err  <= 1'b0;
                rx_ovr  <= 1'b0;
            end
            if (load) begin
                rx_dat  <= shreg;
                rx_full <= 1'b1;
                rx_err  <= ~rxs;
                if (rx_full && !rx_read)
                    rx_ovr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acia_rx.sv
// Directed bench for acia_rx with a scoreboard of expected received bytes.
module tb_acia_rx;

    localparam int SYM = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pclk = 1'b1;
    logic       rx_serial = 1'b1;
    logic       rx_read = 1'b0;
    logic [7:0] rx_dat;
    logic       rx_full;
    logic       rx_err;
    logic       rx_ovr;

    int errors = 0;
    int checks = 0;
    int pdiv = 1;
    int pcnt = 0;
    int cyc;

    typedef struct {
        logic [7:0] dat;
        logic       err;
        logic       ovr;
        logic       full;
    } exp_t;
    exp_t sb[$];

    acia_rx #(.clk_freq(160000), .sym_rate(10000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pclk      (pclk),
        .rx_serial (rx_serial),
        .rx_read   (rx_read),
        .rx_dat    (rx_dat),
        .rx_full   (rx_full),
        .rx_err    (rx_err),
        .rx_ovr    (rx_ovr)
    );

    always #5 clk = ~clk;

    // pclk enable: one tick every pdiv clocks, changed away from posedge.
    always @(negedge clk) begin
        pcnt = (pcnt + 1) % pdiv;
        pclk = (pcnt == 0);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic e, input logic o, input logic f);
        exp_t x;
        x.dat = d; x.err = e; x.ovr = o; x.full = f;
        sb.push_back(x);
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 8'(sb.size()), 8'd1);
        end else begin
            x = sb.pop_front();
            check({tag, ".dat"},  rx_dat,  x.dat);
            check({tag, ".err"},  rx_err,  x.err);
            check({tag, ".ovr"},  rx_ovr,  x.ovr);
            check({tag, ".full"}, rx_full, x.full);
        end
    endtask

    task automatic wait_bit();
        repeat (SYM * pdiv) @(negedge clk);
    endtask

    // Called at a negedge; drives a full 8N1 frame, line left at stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_serial = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            wait_bit();
        end
        rx_serial = stop;
        wait_bit();
    endtask

    task automatic wait_full(input int limit, output int n);
        n = 0;
        while (!rx_full && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!rx_full)
            check("full_timeout", {7'd0, rx_full}, 8'd1);
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst.dat",  rx_dat,  8'h00);
        check("rst.full", rx_full, 8'd0);
        check("rst.err",  rx_err,  8'd0);
        check("rst.ovr",  rx_ovr,  8'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean frame, exact latency: 2 sync + 1 detect + 152 ticks
        push(8'hA5, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'hA5, 1'b1);
            wait_full(400, cyc);
        join
        check("clean.latency", 8'(cyc), 8'd155);
        pop_check("clean");
        pulse_read();
        check("clean.read_full", rx_full, 8'd0);

        // Start glitch: short low pulse must not produce a byte
        repeat (10) @(negedge clk);
        rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        rx_serial = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch.full", rx_full, 8'd0);
        check("glitch.err",  rx_err,  8'd0);
        check("glitch.ovr",  rx_ovr,  8'd0);
        push(8'h3C, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'h3C, 1'b1);
            wait_full(400, cyc);
        join
        check("glitch.next_latency", 8'(cyc), 8'd155);
        pop_check("glitch_next");
        pulse_read();

        // Framing error followed by a held-low break
        repeat (10) @(negedge clk);
        push(8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0);
        pop_check("break");
        pulse_read();
        repeat (40) @(negedge clk);
        check("break.no_retrigger", rx_full, 8'd0);
        rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        check("break.idle_full", rx_full, 8'd0);
        push(8'hC3, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'hC3, 1'b1);
            wait_full(400, cyc);
        join
        check("break.next_latency", 8'(cyc), 8'd155);
        pop_check("after_break");
        pulse_read();

        // Overrun: second byte with no read in between
        repeat (10) @(negedge clk);
        push(8'h11, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'h11, 1'b1);
            wait_full(400, cyc);
        join
        pop_check("ovr_first");
        push(8'h22, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1);
        pop_check("ovr_second");
        pulse_read();
        check("ovr.read_full", rx_full, 8'd0);
        check("ovr.read_err",  rx_err,  8'd0);
        check("ovr.read_ovr",  rx_ovr,  8'd0);

        // Simultaneous rx_read and byte load (stop sample at 155th posedge)
        repeat (10) @(negedge clk);
        push(8'h66, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'h66, 1'b1);
            wait_full(400, cyc);
        join
        pop_check("simul_first");
        push(8'h55, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (154) @(negedge clk);
                pulse_read();
            end
        join
        pop_check("simul");

        // Reset asserted during data bit 3, held until the line is high
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (70) @(negedge clk);
                reset_n = 1'b0;
                repeat (20) @(negedge clk);
                check("midrst.dat",  rx_dat,  8'h00);
                check("midrst.full", rx_full, 8'd0);
                check("midrst.err",  rx_err,  8'd0);
                check("midrst.ovr",  rx_ovr,  8'd0);
                reset_n = 1'b1;
            end
        join
        repeat (40) @(negedge clk);
        check("midrst.no_byte", rx_full, 8'd0);

        // pclk every 4th clk: same byte, roughly 4x the clk count
        pdiv = 4;
        repeat (8) @(negedge clk);
        push(8'hA5, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'hA5, 1'b1);
            wait_full(1200, cyc);
        join
        check("gated.latency_window", {7'd0, (cyc >= 608 && cyc <= 616)}, 8'd1);
        pop_check("gated");
        pulse_read();
        repeat (4) @(negedge clk);
        check("gated.read_full", rx_full, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
